// File: rtl/hex_display_pkg.sv
// Shared segment encodings for the active-low seven-segment HEX displays.
// Pure constants: no latency, no flow control.
package hex_display_pkg;

  // Segment bit order is bit0=a .. bit6=g; a 0 lights the segment.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_ALL   = 7'h00;

endpackage

// File: rtl/hex_digit_to_seg.sv
// Decodes one hex nibble to an active-low seven-segment pattern.
// Combinational, zero latency, no flow control.
module hex_digit_to_seg
  import hex_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex display driver: load register, LZ blanking, blink, lamp test.
// LOAD to HEX is 2 cycles, control inputs to HEX 1 cycle; no backpressure, always accepts.
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] VALUE,
  input  logic                  LOAD,
  input  logic                  LZ_EN,
  input  logic [N_DIGITS-1:0]   BLINK_MASK,
  input  logic                  LAMP_TEST,
  output logic [7*N_DIGITS-1:0] HEX,
  output logic                  BLINK_PHASE
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [4*N_DIGITS-1:0] value_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  blink_q;
  logic [7*N_DIGITS-1:0] seg_raw;
  logic [7*N_DIGITS-1:0] hex_d;
  logic [7*N_DIGITS-1:0] hex_q;
  logic [N_DIGITS-1:0]   lz_blank;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (LOAD) begin
      value_q <= VALUE;
    end
  end

  // Free-running blink prescaler; the phase flips on each wrap.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    hex_digit_to_seg u_dec (
      .digit (value_q[4*g +: 4]),
      .seg   (seg_raw[7*g +: 7])
    );
  end

  // Zero run scanned from the most significant digit down; digit 0 never blanks.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & (value_q[4*i +: 4] == 4'h0);
      lz_blank[i] = LZ_EN & zero_run & (i > 0);
    end
  end

  always_comb begin
    hex_d = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (LAMP_TEST) begin
        hex_d[7*i +: 7] = SEG_ALL;
      end else if (blink_q && BLINK_MASK[i]) begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end else if (lz_blank[i]) begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end else begin
        hex_d[7*i +: 7] = seg_raw[7*i +: 7];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hex_q <= {N_DIGITS{SEG_BLANK}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign HEX         = hex_q;
  assign BLINK_PHASE = blink_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Randomised and directed bench for hex_display_driver against a cycle-count reference model.
module tb_hex_display_driver;

  localparam int ND = 4;
  localparam int BD = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [15:0]    value = '0;
  logic           load = 1'b0;
  logic           lz = 1'b0;
  logic [ND-1:0]  mask = '0;
  logic           lamp = 1'b0;
  logic [7*ND-1:0] hex;
  logic           phase_o;

  int checks = 0;
  int errors = 0;

  // Reference state: loaded value, edges since reset, expected HEX.
  logic [15:0]     m_val = '0;
  int              m_cnt = 0;
  logic [7*ND-1:0] m_hex = '1;
  logic [6:0]      seg_tbl [16];

  hex_display_driver #(.N_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .VALUE       (value),
    .LOAD        (load),
    .LZ_EN       (lz),
    .BLINK_MASK  (mask),
    .LAMP_TEST   (lamp),
    .HEX         (hex),
    .BLINK_PHASE (phase_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic m_phase();
    return ((m_cnt / BD) % 2) == 1;
  endfunction

  function automatic logic [7*ND-1:0] model_hex(input logic [15:0] v, input logic ph);
    logic [7*ND-1:0] r;
    logic [15:0] upper;
    r = '1;
    for (int i = 0; i < ND; i++) begin
      upper = v >> (4 * i);
      if (lamp)                        r[7*i +: 7] = 7'h00;
      else if (ph && mask[i])          r[7*i +: 7] = 7'h7F;
      else if (lz && i > 0 && upper == 16'h0) r[7*i +: 7] = 7'h7F;
      else                             r[7*i +: 7] = seg_tbl[v[4*i +: 4]];
    end
    return r;
  endfunction

  // One clock edge; the model consumes the inputs the DUT just sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_val = '0;
      m_cnt = 0;
      m_hex = '1;
    end else begin
      m_hex = model_hex(m_val, m_phase());
      if (load) m_val = value;
      m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (hex !== '1) begin errors++; $display("FAIL reset_hex got %h want %h", hex, {7*ND{1'b1}}); end
    checks++;
    if (phase_o !== 1'b0) begin errors++; $display("FAIL reset_phase got %b want 0", phase_o); end
    tick();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (hex !== m_hex) begin errors++; $display("FAIL release_hex cyc %0d got %h want %h", n, hex, m_hex); end
      checks++;
      if (phase_o !== m_phase()) begin errors++; $display("FAIL release_phase cyc %0d got %b want %b", n, phase_o, m_phase()); end
      if (n == 1) begin
        checks++;
        if (hex !== {ND{7'b1000000}}) begin errors++; $display("FAIL release_zeros got %h want %h", hex, {ND{7'b1000000}}); end
      end
    end
  endtask

  task automatic test_load();
    logic [7*ND-1:0] want;
    want = {7'b0001000, 7'b0010010, 7'b0001110, 7'b1000000};
    lz = 1'b0; mask = '0; lamp = 1'b0;
    value = 16'hA5F0; load = 1'b1;
    tick();
    load = 1'b0; value = 16'($urandom);
    tick();
    checks++;
    if (hex !== want) begin errors++; $display("FAIL load_a5f0 got %h want %h", hex, want); end
    for (int n = 0; n < 3; n++) begin
      value = 16'($urandom);
      tick();
      checks++;
      if (hex !== want) begin errors++; $display("FAIL load_hold cyc %0d got %h want %h", n, hex, want); end
    end
  endtask

  task automatic test_lz();
    logic [7*ND-1:0] want;
    lz = 1'b1; mask = '0; lamp = 1'b0;
    value = 16'h0040; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    want = {7'h7F, 7'h7F, 7'b0011001, 7'b1000000};
    checks++;
    if (hex !== want) begin errors++; $display("FAIL lz_0040 got %h want %h", hex, want); end
    value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    want = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};
    checks++;
    if (hex !== want) begin errors++; $display("FAIL lz_0000 got %h want %h", hex, want); end
    checks++;
    if (hex !== m_hex) begin errors++; $display("FAIL lz_model got %h want %h", hex, m_hex); end
  endtask

  task automatic test_blink();
    logic prev;
    int   last;
    lz = 1'b0; lamp = 1'b0; mask = 4'b0010;
    value = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    prev = phase_o;
    last = -1;
    for (int n = 0; n < 24; n++) begin
      tick();
      checks++;
      if (hex !== m_hex) begin errors++; $display("FAIL blink_hex cyc %0d got %h want %h", n, hex, m_hex); end
      checks++;
      if (phase_o !== m_phase()) begin errors++; $display("FAIL blink_phase cyc %0d got %b want %b", n, phase_o, m_phase()); end
      if (phase_o !== prev) begin
        if (last >= 0) begin
          checks++;
          if (n - last != BD) begin errors++; $display("FAIL blink_period got %0d want %0d", n - last, BD); end
        end
        last = n;
      end
      prev = phase_o;
    end
  endtask

  task automatic test_lamp();
    int guard;
    lz = 1'b1; mask = 4'b1111; lamp = 1'b0;
    guard = 0;
    while (!m_phase() && guard < 16) begin
      tick();
      guard++;
    end
    checks++;
    if (!m_phase()) begin errors++; $display("FAIL lamp_wait got phase %b want 1", phase_o); end
    lamp = 1'b1;
    tick();
    checks++;
    if (hex !== '0) begin errors++; $display("FAIL lamp_on got %h want 0", hex); end
    lamp = 1'b0;
    tick();
    checks++;
    if (hex !== m_hex) begin errors++; $display("FAIL lamp_off got %h want %h", hex, m_hex); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 250; n++) begin
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      load  = ($urandom_range(0, 2) == 0);
      lz    = 1'($urandom);
      mask  = 4'($urandom);
      lamp  = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (hex !== m_hex) begin errors++; $display("FAIL rand_hex cyc %0d got %h want %h", n, hex, m_hex); end
      checks++;
      if (phase_o !== m_phase()) begin errors++; $display("FAIL rand_phase cyc %0d got %b want %b", n, phase_o, m_phase()); end
    end
    load = 1'b0; lamp = 1'b0;
  endtask

  task automatic test_async_reset();
    int  guard;
    int  edges;
    logic seen;
    lz = 1'b1; lamp = 1'b0; mask = 4'b0010;
    value = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    guard = 0;
    while (!((m_cnt % BD) == 2 && m_phase()) && guard < 16) begin
      tick();
      guard++;
    end
    checks++;
    if (!((m_cnt % BD) == 2 && m_phase())) begin errors++; $display("FAIL arst_wait got cnt %0d want mid dark phase", m_cnt); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (hex !== '1) begin errors++; $display("FAIL arst_hex got %h want %h", hex, {7*ND{1'b1}}); end
    checks++;
    if (phase_o !== 1'b0) begin errors++; $display("FAIL arst_phase got %b want 0", phase_o); end
    tick();
    rst = 1'b0;
    edges = 0;
    seen  = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      edges++;
      checks++;
      if (hex !== m_hex) begin errors++; $display("FAIL arst_hex_after cyc %0d got %h want %h", n, hex, m_hex); end
      if (phase_o === 1'b1 && !seen) begin
        seen = 1'b1;
        checks++;
        if (edges != BD) begin errors++; $display("FAIL arst_first_toggle got %0d want %0d", edges, BD); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL arst_no_toggle got 0 want 1"); end
  endtask

  initial begin
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    test_reset();
    test_load();
    test_lz();
    test_blink();
    test_lamp();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
